// File: rtl/timer_pkg.sv
// Shared constants and types for the APB timer: register map, TCR layout, write masks.
// Build option TIMER_IRQ_EN widens the TCR write mask to include the interrupt enables.
package timer_pkg;

  localparam logic [7:0] ADDR_TDR  = 8'h00;
  localparam logic [7:0] ADDR_TCR  = 8'h01;
  localparam logic [7:0] ADDR_TSR  = 8'h02;
  localparam logic [7:0] ADDR_TCNT = 8'h03;

  localparam int TCR_CKS_LSB = 0;
  localparam int TCR_OVF_IE  = 2;
  localparam int TCR_UDF_IE  = 3;
  localparam int TCR_DOWN    = 4;
  localparam int TCR_LOAD    = 5;
  localparam int TCR_EN      = 7;

  localparam int TSR_OVF = 0;
  localparam int TSR_UDF = 1;

  typedef enum logic [1:0] {
    CKS_DIV2  = 2'b00,
    CKS_DIV4  = 2'b01,
    CKS_DIV8  = 2'b10,
    CKS_DIV16 = 2'b11
  } cks_e;

  // Field order mirrors the bit positions above, MSB first.
  typedef struct packed {
    logic en;
    logic rsvd6;
    logic load;
    logic down;
    logic udf_ie;
    logic ovf_ie;
    cks_e cks;
  } tcr_t;

  localparam logic [7:0] TCR_WMASK_BASE = 8'hB3;
  localparam logic [7:0] TCR_WMASK_IRQ  = 8'hBF;

`ifdef TIMER_IRQ_EN
  localparam logic [7:0] TCR_WMASK = TCR_WMASK_IRQ;
`else
  localparam logic [7:0] TCR_WMASK = TCR_WMASK_BASE;
`endif

endpackage

// File: rtl/timer_if.sv
// APB bus bundle between the peripheral bus master and the timer slave.
interface timer_if;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [7:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pready;
  logic       pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/timer_prescaler.sv
// Free-running 4-bit prescaler; selects one bit as clk_div and emits a one-cycle
// tick on its rising edge so the counter stays in the pclk domain.
module timer_prescaler
  import timer_pkg::*;
(
  input  logic pclk,
  input  logic preset_n,
  input  cks_e cks,
  output logic clk_div,
  output logic tick
);

  logic [3:0] cnt;
  logic       clk_div_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      cnt       <= '0;
      clk_div_q <= 1'b0;
    end else begin
      cnt       <= cnt + 4'd1;
      clk_div_q <= clk_div;
    end
  end

  // Bit n of the counter toggles every 2^n cycles: a 50% duty divide by 2^(n+1).
  assign clk_div = cnt[cks];
  assign tick    = clk_div & ~clk_div_q;

endmodule

// File: rtl/timer_testbench.sv
// 8-bit APB timer: wait-state logic, TDR/TCR/TSR/TCNT registers, up/down counter.
// Define TIMER_IRQ_EN to add the OVF/UDF interrupt enables and the irq output.
module timer_testbench
  import timer_pkg::*;
#(
  parameter int WAIT = 7
) (
  input  logic   pclk,
  input  logic   preset_n,
  timer_if.slave apb,
  output logic   clk_div,
  output logic   tmr_ovf,
  output logic   tmr_udf
`ifdef TIMER_IRQ_EN
  ,
  output logic   irq
`endif
);

  localparam int WCW = (WAIT > 0) ? $clog2(WAIT + 1) : 1;

  logic [WCW-1:0] wait_cnt;
  logic           access;
  logic           wr_en;
  logic           addr_hit;
  logic [7:0]     rd_data;

  tcr_t       tcr;
  logic [7:0] tdr;
  logic [7:0] tcnt;
  logic [7:0] tcnt_next;
  logic [1:0] tsr;
  logic [1:0] tsr_next;
  logic [1:0] tsr_clr;
  logic       ovf_set;
  logic       udf_set;
  logic       tick;

  // ---------------- APB access phase ----------------
  assign access     = apb.psel & apb.penable;
  assign apb.pready = access && (wait_cnt == WCW'(WAIT));
  assign wr_en      = access & apb.pwrite & apb.pready;
  assign addr_hit   = (apb.paddr[7:2] == 6'd0);

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n)                   wait_cnt <= '0;
    else if (access && !apb.pready) wait_cnt <= wait_cnt + 1'b1;
    else                             wait_cnt <= '0;
  end

  // ---------------- Prescaler ----------------
  timer_prescaler u_prescaler (
    .pclk     (pclk),
    .preset_n (preset_n),
    .cks      (tcr.cks),
    .clk_div  (clk_div),
    .tick     (tick)
  );

  // ---------------- Counter and flags ----------------
  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    tcnt_next = tcnt;
    ovf_set   = 1'b0;
    udf_set   = 1'b0;
    if (tcr.load) begin
      tcnt_next = tdr;
    end else if (tcr.en && tick) begin
      if (tcr.down) begin
        tcnt_next = tcnt - 8'd1;
        udf_set   = (tcnt == 8'h00);
      end else begin
        tcnt_next = tcnt + 8'd1;
        ovf_set   = (tcnt == 8'hFF);
      end
    end
  end

  // Writing 0 clears a flag; a set in the same cycle still wins.
  assign tsr_clr  = (wr_en && apb.paddr == ADDR_TSR) ? ~apb.pwdata[1:0] : 2'b00;
  assign tsr_next = (tsr & ~tsr_clr) | {udf_set, ovf_set};

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      tdr  <= '0;
      tcr  <= '0;
      tsr  <= '0;
      tcnt <= '0;
    end else begin
      if (wr_en && apb.paddr == ADDR_TDR) tdr <= apb.pwdata;
      if (wr_en && apb.paddr == ADDR_TCR) tcr <= tcr_t'(apb.pwdata & TCR_WMASK);
      tsr  <= tsr_next;
      tcnt <= tcnt_next;
    end
  end

  // ---------------- Read path ----------------
  always_comb begin
    rd_data = '0;
    case (apb.paddr)
      ADDR_TDR:  rd_data = tdr;
      ADDR_TCR:  rd_data = tcr;
      ADDR_TSR:  rd_data = {6'd0, tsr};
      ADDR_TCNT: rd_data = tcnt;
      default:   rd_data = '0;
    endcase
  end

  assign apb.prdata  = apb.pready ? rd_data : 8'h00;
  assign apb.pslverr = apb.pready & ~addr_hit;

  assign tmr_ovf = tsr[TSR_OVF];
  assign tmr_udf = tsr[TSR_UDF];

`ifdef TIMER_IRQ_EN
  assign irq = (tsr[TSR_OVF] & tcr.ovf_ie) | (tsr[TSR_UDF] & tcr.udf_ie);
`endif

endmodule

// File: tb/tb_timer_testbench.sv
// Scoreboard bench for the APB timer: stimulus queues expected responses, a
// negedge monitor compares them whenever a transfer completes.
module tb_timer_testbench;
  import timer_pkg::*;

  localparam int WAIT = 7;
`ifdef TIMER_IRQ_EN
  localparam logic [7:0] EXP_TCR_MASK = 8'hBF;
`else
  localparam logic [7:0] EXP_TCR_MASK = 8'hB3;
`endif

  logic pclk     = 1'b0;
  logic preset_n = 1'b0;
  logic clk_div, tmr_ovf, tmr_udf;
`ifdef TIMER_IRQ_EN
  logic irq;
`endif

  timer_if bus ();

  timer_testbench #(.WAIT(WAIT)) dut (
    .pclk     (pclk),
    .preset_n (preset_n),
    .apb      (bus),
    .clk_div  (clk_div),
    .tmr_ovf  (tmr_ovf),
    .tmr_udf  (tmr_udf)
`ifdef TIMER_IRQ_EN
    ,
    .irq      (irq)
`endif
  );

  always #5 pclk = ~pclk;

  typedef struct {
    string      name;
    logic       is_rd;
    logic [7:0] data;
    logic       err;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  // Shadow of the programmed registers and a port-level model of TCNT.
  logic [7:0] tb_tcr    = 8'h00;
  logic [7:0] tb_tdr    = 8'h00;
  logic [7:0] model_cnt = 8'h00;
  logic       prev_div  = 1'b0;
  logic       obs_tick;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare on every completed transfer.
  always @(negedge pclk) begin
    if (preset_n && bus.psel && bus.penable && bus.pready) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected transfer: addr 0x%0h with empty scoreboard", bus.paddr);
      end else begin
        mon_e = sb_q.pop_front();
        if (mon_e.is_rd)
          check(mon_e.name, {23'd0, bus.pslverr, bus.prdata}, {23'd0, mon_e.err, mon_e.data});
        else
          check({mon_e.name, " err"}, 32'(bus.pslverr), 32'(mon_e.err));
      end
    end
  end

  // TCNT model: tick is a 0->1 of clk_div seen across consecutive cycles.
  always @(negedge pclk) begin
    if (!preset_n) begin
      prev_div  = 1'b0;
      model_cnt = 8'h00;
    end else begin
      obs_tick = clk_div & ~prev_div;
      prev_div = clk_div;
      if (tb_tcr[5])
        model_cnt = tb_tdr;
      else if (tb_tcr[7] && obs_tick)
        model_cnt = tb_tcr[4] ? model_cnt - 8'd1 : model_cnt + 8'd1;
    end
  end

  task automatic apb(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                     input logic [7:0] exp_rd, input string name);
    int   cyc;
    bit   done;
    exp_t e;
    e.name  = name;
    e.is_rd = !wr;
    e.data  = exp_rd;
    e.err   = (addr > 8'h03);
    sb_q.push_back(e);
    @(posedge pclk); #1;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr;
    bus.paddr = addr; bus.pwdata = wdata;
    @(posedge pclk); #1;
    bus.penable = 1'b1;
    cyc  = 0;
    done = 0;
    while (!done && cyc < 50) begin
      @(negedge pclk);
      cyc++;
      if (bus.pready) done = 1;
      @(posedge pclk); #1;
    end
    check({name, " ready cycle"}, 32'(cyc), 32'(WAIT + 1));
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    if (wr && done) begin
      if (addr == 8'h00) tb_tdr = wdata;
      if (addr == 8'h01) tb_tcr = wdata & EXP_TCR_MASK;
    end
  endtask

  task automatic wr(input logic [7:0] addr, input logic [7:0] data, input string name);
    apb(1'b1, addr, data, 8'h00, name);
  endtask

  task automatic rd(input logic [7:0] addr, input logic [7:0] exp, input string name);
    apb(1'b0, addr, 8'h00, exp, name);
  endtask

  task automatic count_rises(input int n, input int exp, input string name);
    int   rises;
    logic prev;
    @(negedge pclk);
    prev  = clk_div;
    rises = 0;
    repeat (n) begin
      @(negedge pclk);
      if (clk_div && !prev) rises++;
      prev = clk_div;
    end
    check(name, 32'(rises), 32'(exp));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " prdata"},  32'(bus.prdata),  32'd0);
    check({tag, " pready"},  32'(bus.pready),  32'd0);
    check({tag, " pslverr"}, 32'(bus.pslverr), 32'd0);
    check({tag, " clk_div"}, 32'(clk_div),     32'd0);
    check({tag, " tmr_ovf"}, 32'(tmr_ovf),     32'd0);
    check({tag, " tmr_udf"}, 32'(tmr_udf),     32'd0);
  endtask

  initial begin
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = 8'h00; bus.pwdata = 8'h00;

    repeat (3) @(negedge pclk);
    check_outputs_zero("reset");
    preset_n = 1'b1;

    // Prescaler divide ratios.
    wr(ADDR_TCR, 8'h00, "tcr=00");
    rd(ADDR_TCR, 8'h00, "rd tcr 00");
    count_rises(100, 50, "div2 edges");
    wr(ADDR_TCR, 8'h01, "tcr=01");
    rd(ADDR_TCR, 8'h01, "rd tcr 01");
    count_rises(100, 25, "div4 edges");
    wr(ADDR_TCR, 8'h02, "tcr=02");
    count_rises(104, 13, "div8 edges");
    wr(ADDR_TCR, 8'h03, "tcr=03");
    count_rises(112, 7, "div16 edges");

    // Writable mask.
    wr(ADDR_TCR, 8'hFF, "tcr=ff");
    rd(ADDR_TCR, EXP_TCR_MASK, "rd tcr mask");
    wr(ADDR_TCR, 8'h00, "tcr clear");

    // Up count through 0xFF -> 0x00.
    wr(ADDR_TDR, 8'hFE, "tdr=fe");
    rd(ADDR_TDR, 8'hFE, "rd tdr");
    wr(ADDR_TCR, 8'h20, "tcr load");
    rd(ADDR_TCNT, 8'hFE, "rd tcnt loaded");
    wr(ADDR_TCR, 8'h80, "tcr en up");
    wr(ADDR_TCR, 8'h00, "tcr stop up");
    rd(ADDR_TCNT, model_cnt, "rd tcnt up");
    rd(ADDR_TSR, 8'h01, "rd tsr ovf");
    check("tmr_ovf set", 32'(tmr_ovf), 32'd1);
    check("tmr_udf clear", 32'(tmr_udf), 32'd0);
    wr(ADDR_TSR, 8'h03, "tsr write ones");
    rd(ADDR_TSR, 8'h01, "rd tsr sticky");
    wr(ADDR_TSR, 8'h00, "tsr clear");
    rd(ADDR_TSR, 8'h00, "rd tsr cleared");
    check("tmr_ovf cleared", 32'(tmr_ovf), 32'd0);
    wr(ADDR_TCNT, 8'h55, "tcnt write");
    rd(ADDR_TCNT, model_cnt, "rd tcnt after ro write");

    // Down count through 0x00 -> 0xFF.
    wr(ADDR_TDR, 8'h01, "tdr=01");
    wr(ADDR_TCR, 8'h20, "tcr load dn");
    rd(ADDR_TCNT, 8'h01, "rd tcnt loaded dn");
    wr(ADDR_TCR, 8'h90, "tcr en down");
    wr(ADDR_TCR, 8'h10, "tcr stop down");
    rd(ADDR_TCNT, model_cnt, "rd tcnt down");
    rd(ADDR_TSR, 8'h02, "rd tsr udf");
    check("tmr_udf set", 32'(tmr_udf), 32'd1);

    // Unmapped address.
    rd(8'h10, 8'h00, "rd unmapped");
    wr(8'h10, 8'hA5, "wr unmapped");

    // Reset while counting.
    wr(ADDR_TCR, 8'h80, "tcr run");
    repeat (7) @(posedge pclk);
    #3;
    preset_n = 1'b0;
    tb_tcr   = 8'h00;
    tb_tdr   = 8'h00;
    #1;
    check_outputs_zero("mid reset");
    repeat (2) @(negedge pclk);
    preset_n = 1'b1;
    rd(ADDR_TCR, 8'h00, "rd tcr post reset");
    rd(ADDR_TSR, 8'h00, "rd tsr post reset");
    rd(ADDR_TCNT, 8'h00, "rd tcnt post reset");

    repeat (4) @(negedge pclk);
    check("scoreboard drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
